// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
package ifu_prefetch_pkg;

  localparam int          CADDR_W_DEF  = 25;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        READ_EN      = 1'b1;
  localparam logic        WRITE_EN     = 1'b0;
  localparam logic [3:0]  BYTE_EN_NONE = 4'h0;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifu_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO for the prefetch buffer: push/pop/clear with count/full/empty.
// Storage is not reset; only pointers and count are.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear;

  // Next pointer and occupancy; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Pipelined instruction fetch with in-order prefetch buffer.
// Issues up to MAX_OUTST icache reads, each holding a reserved buffer slot,
// queues returned words with their PCs and hands them to ID over valid/ready.
// Redirects (jump or jtag soft reset) flush the buffer and drop stale responses.
// Optional feature macro: IFU_PERF_CNT_EN adds fetch/flush/drop event counters.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          CADDR_W    = CADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jtag_reset_flag_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [31:0]        inst_o,
  output logic [31:0]        inst_addr_o,
  output logic [CADDR_W-1:0] o_p_addr,
  output logic               o_p_read,
  output logic               o_p_write,
  output logic [3:0]         o_p_byte_en,
  output logic [31:0]        o_p_writedata,
  input  logic [31:0]        i_p_readdata,
  input  logic               i_p_readdata_valid,
  input  logic               i_p_waitrequest
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_o,
  output logic [15:0]        perf_flush_o,
  output logic [15:0]        perf_drop_o
`endif
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;

  logic          flush, issue, accept, rsp, rsp_keep, rsp_discard, pop;
  logic [31:0]   flush_pc;
  logic [CW:0]   inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  ifu_entry_t    push_entry, head;

  // jtag soft reset behaves as a redirect to RESET_PC and takes priority.
  assign flush    = jump_flag_i || jtag_reset_flag_i;
  assign flush_pc = jtag_reset_flag_i ? RESET_PC : word_align(jump_addr_i);

  // Credit check: every accepted read already owns a buffer slot.
  assign inflight = {1'b0, fifo_count} + (CW+1)'(outst_q);
  assign issue    = rst_n && !flush && (outst_q < OW'(MAX_OUTST)) &&
                    (inflight < (CW+1)'(FIFO_DEPTH));
  assign accept   = issue && !i_p_waitrequest;

  // A response with nothing outstanding is a bus error and is ignored.
  assign rsp         = i_p_readdata_valid && (outst_q != '0);
  assign rsp_discard = rsp && (flush || (drop_q != '0));
  assign rsp_keep    = rsp && !rsp_discard;

  assign inst_valid_o = !fifo_empty && !flush;
  assign pop          = inst_valid_o && inst_ready_i;

  assign push_entry.pc   = resp_pc_q;
  assign push_entry.inst = i_p_readdata;

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ifu_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (rsp_keep),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next fetch/response PCs and the outstanding/drop counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + OW'(accept) - OW'(rsp);
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp_keep) resp_pc_d = resp_pc_q + 32'd4;
    if (rsp && !flush && (drop_q != '0)) drop_d = drop_q - OW'(1);
    if (flush) begin
      fetch_pc_d = flush_pc;
      resp_pc_d  = flush_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = outst_d;
    end
  end

  // Fetch control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  assign inst_o        = fifo_empty ? ZERO_WORD : head.inst;
  assign inst_addr_o   = fifo_empty ? ZERO_WORD : head.pc;
  assign o_p_addr      = {{(CADDR_W-21){1'b0}}, fetch_pc_q[22:2]};
  assign o_p_read      = READ_EN & issue;
  assign o_p_write     = WRITE_EN;
  assign o_p_byte_en   = BYTE_EN_NONE;
  assign o_p_writedata = ZERO_WORD;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [15:0] perf_flush_q, perf_flush_d;
  logic [15:0] perf_drop_q, perf_drop_d;

  // Event counters: delivered words, jump redirects, discarded responses.
  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(pop);
    perf_flush_d = perf_flush_q + 16'(jump_flag_i);
    perf_drop_d  = perf_drop_q + 16'(rsp_discard);
  end

  // Counters clear only on rst_n, never on jtag reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_flush_o = perf_flush_q;
  assign perf_drop_o  = perf_drop_q;
`endif

`ifndef SYNTHESIS
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    i_p_readdata_valid |-> (outst_q != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_keep && fifo_full) |-> pop);
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: queue-based reference model, in-order bus responder
// with configurable latency, directed scenarios with literal expectations.
module tb_ifu_prefetch;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jtag = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jaddr = 32'h0;
  logic        ready = 1'b0;
  logic        waitreq = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        rvalid = 1'b0;

  logic        inst_valid_o;
  logic [31:0] inst_o, inst_addr_o;
  logic [24:0] o_p_addr;
  logic        o_p_read, o_p_write;
  logic [3:0]  o_p_byte_en;
  logic [31:0] o_p_writedata;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [15:0] perf_flush_o, perf_drop_o;
`endif

  ifu_prefetch #(
    .FIFO_DEPTH (DEPTH),
    .MAX_OUTST  (MAXO),
    .RESET_PC   (RPC),
    .CADDR_W    (25)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .jtag_reset_flag_i  (jtag),
    .jump_flag_i        (jump),
    .jump_addr_i        (jaddr),
    .inst_valid_o       (inst_valid_o),
    .inst_ready_i       (ready),
    .inst_o             (inst_o),
    .inst_addr_o        (inst_addr_o),
    .o_p_addr           (o_p_addr),
    .o_p_read           (o_p_read),
    .o_p_write          (o_p_write),
    .o_p_byte_en        (o_p_byte_en),
    .o_p_writedata      (o_p_writedata),
    .i_p_readdata       (rdata),
    .i_p_readdata_valid (rvalid),
    .i_p_waitrequest    (waitreq)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_o       (perf_fetch_o),
    .perf_flush_o       (perf_flush_o),
    .perf_drop_o        (perf_drop_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] pc; int due; } req_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  ent_t        m_q[$];
  req_t        rq[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_inst[$];
  int          dlv_cyc[$];
  logic [31:0] m_fetch = RPC;
  logic [31:0] m_resp = RPC;
  int          m_outst = 0;
  int          m_drop = 0;
  logic [31:0] m_pf_fetch = 0;
  logic [15:0] m_pf_flush = 0;
  logic [15:0] m_pf_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory image: word at pc reads as pc ^ DEADBEEF.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  // In-order bus responder; one response per cycle once its latency has elapsed.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n && rq.size() > 0 && cyc >= rq[0].due) begin
      rvalid = 1'b1;
      rdata  = mem_word(rq[0].pc);
      rq.delete(0);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  end

  // Reference model + per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin : mon
    logic        fl, e_read, e_valid, acc, pp;
    logic [31:0] tgt;
    if (!rst_n) begin
      chk("rst_read", {31'b0, o_p_read}, 32'h0);
      chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_addr", inst_addr_o, 32'h0);
      m_q.delete();
      rq.delete();
      m_fetch = RPC; m_resp = RPC; m_outst = 0; m_drop = 0;
      m_pf_fetch = 0; m_pf_flush = 0; m_pf_drop = 0;
    end else begin
      fl      = jump || jtag;
      e_read  = !fl && (m_outst < MAXO) && ((m_outst + m_q.size()) < DEPTH);
      e_valid = (m_q.size() > 0) && !fl;
      chk("read", {31'b0, o_p_read}, {31'b0, e_read});
      chk("valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
      if (e_read) chk("p_addr", 32'(o_p_addr), {11'b0, m_fetch[22:2]});
      chk("inst", inst_o, (m_q.size() > 0) ? m_q[0].inst : 32'h0);
      chk("inst_addr", inst_addr_o, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
      chk("wr_side", {o_p_writedata[27:0], o_p_byte_en} | {31'b0, o_p_write}, 32'h0);
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_o, m_pf_fetch);
      chk("perf_flush", {16'b0, perf_flush_o}, {16'b0, m_pf_flush});
      chk("perf_drop", {16'b0, perf_drop_o}, {16'b0, m_pf_drop});
`endif
      acc = e_read && !waitreq;
      pp  = e_valid && ready;
      if (pp) begin
        dlv_pc.push_back(m_q[0].pc);
        dlv_inst.push_back(m_q[0].inst);
        dlv_cyc.push_back(cyc);
        m_q.delete(0);
        m_pf_fetch++;
      end
      if (rvalid) begin
        if (m_outst > 0) m_outst--;
        if (fl) m_pf_drop++;
        else if (m_drop > 0) begin m_drop--; m_pf_drop++; end
        else begin
          m_q.push_back('{pc: m_resp, inst: rdata});
          m_resp += 32'd4;
        end
      end
      if (fl) begin
        tgt = jtag ? RPC : {jaddr[31:2], 2'b00};
        m_q.delete();
        m_fetch = tgt; m_resp = tgt;
        m_drop  = m_outst;
        if (jump) m_pf_flush++;
      end
      if (acc) begin
        rq.push_back('{pc: m_fetch, due: cyc + lat});
        m_fetch += 32'd4;
        m_outst++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_dlv(input int n, input int budget);
    int k = 0;
    while (dlv_pc.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (dlv_pc.size() < n) chk("dlv_timeout", dlv_pc.size(), n);
  endtask

  initial begin
    logic [24:0] addr0;
    logic [31:0] first;
    int          k;

    // Reset values while rst_n is held low.
    #2;
    chk("init_read", {31'b0, o_p_read}, 32'h0);
    chk("init_valid", {31'b0, inst_valid_o}, 32'h0);
    step(3);

    // Streaming from RESET_PC with ready=1 and no waitrequest.
    rst_n = 1'b1;
    ready = 1'b1;
    wait_dlv(8, 100);
    for (int i = 0; i < 8; i++) chk("stream_pc", dlv_pc[i], 32'(i * 4));
    chk("stream_inst0", dlv_inst[0], 32'hDEAD_BEEF);
    chk("stream_inst1", dlv_inst[1], 32'hDEAD_BEEB);
    chk("stream_gapless", 32'(dlv_cyc[7] - dlv_cyc[0]), 32'd7);

    // ID stalls for 20 cycles: buffer fills to DEPTH, reads stop.
    ready = 1'b0;
    dlv_pc.delete();
    step(20);
    chk("stall_none_out", dlv_pc.size(), 32'd0);
    chk("stall_fill", m_q.size(), 32'd4);
    chk("stall_read_off", {31'b0, o_p_read}, 32'h0);
    chk("stall_valid", {31'b0, inst_valid_o}, 32'h1);
    first = m_q[0].pc;
    ready = 1'b1;
    wait_dlv(6, 100);
    for (int i = 0; i < 6; i++) chk("stall_order", dlv_pc[i], first + 32'(4 * i));

    // Waitrequest for 5 cycles: address and read held.
    step(10);
    waitreq = 1'b1;
    addr0 = o_p_addr;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("wait_read", {31'b0, o_p_read}, 32'h1);
      chk("wait_addr", 32'(o_p_addr), 32'(addr0));
    end
    waitreq = 1'b0;
    dlv_pc.delete();
    wait_dlv(4, 50);
    for (int i = 0; i < 3; i++) chk("wait_order", dlv_pc[i + 1] - dlv_pc[i], 32'd4);

    // Redirect to 0x1002 with two reads in flight.
    lat = 3;
    k = 0;
    while (m_outst != 2 && k < 50) begin step(1); k++; end
    chk("redir_inflight", m_outst, 32'd2);
    jump  = 1'b1;
    jaddr = 32'h0000_1002;
    #1;
    chk("redir_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("redir_noread", {31'b0, o_p_read}, 32'h0);
    step(1);
    jump = 1'b0;
    dlv_pc.delete();
    dlv_inst.delete();
    wait_dlv(1, 60);
    chk("redir_pc", dlv_pc[0], 32'h0000_1000);
    chk("redir_inst", dlv_inst[0], 32'hDEAD_AEEF);

    // Redirect landing in the same cycle as a response.
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (!(rvalid && m_outst == 2) && k < 60);
    chk("coincide_seen", {31'b0, rvalid}, 32'h1);
    jump  = 1'b1;
    jaddr = 32'h0000_2000;
    @(negedge clk);
    #1;
    chk("coincide_drop", m_drop, 32'd1);
    chk("coincide_outst", m_outst, 32'd1);
    step(1);
    jump = 1'b0;
    dlv_pc.delete();
    dlv_inst.delete();
    wait_dlv(1, 60);
    chk("coincide_pc", dlv_pc[0], 32'h0000_2000);
    chk("coincide_inst", dlv_inst[0], 32'hDEAD_9EEF);
`ifdef IFU_PERF_CNT_EN
    chk("perf_flush_two", {16'b0, perf_flush_o}, 32'd2);
`endif

    // Asynchronous reset mid-cycle, then a jtag soft-reset pulse.
    lat = 1;
    step(5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_read", {31'b0, o_p_read}, 32'h0);
    chk("async_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("async_inst", inst_o, 32'h0);
    chk("async_addr", inst_addr_o, 32'h0);
    step(2);
    rst_n = 1'b1;
    jtag  = 1'b1;
    #1;
    chk("jtag_noread", {31'b0, o_p_read}, 32'h0);
    step(2);
    jtag = 1'b0;
    dlv_pc.delete();
    wait_dlv(3, 50);
    chk("jtag_pc0", dlv_pc[0], 32'h0);
    chk("jtag_pc1", dlv_pc[1], 32'h4);
    chk("jtag_pc2", dlv_pc[2], 32'h8);
`ifdef IFU_PERF_CNT_EN
    chk("perf_flush_jtag", {16'b0, perf_flush_o}, 32'd0);
`endif

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
